// File: rtl/rast_pkg.sv
// Shared rasteriser constants: default fixed-point geometry and sample scheduler states.
package rast_pkg;
  localparam int SIGFIG_DEF = 24;
  localparam int RADIX_DEF  = 10;
  localparam int SAMPS_DEF  = 4;

  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE  = 1'b0;
  localparam state_t ST_ISSUE = 1'b1;
endpackage

// File: rtl/samp_step_gen.sv
// Per-lane sample x generation for one batch: cur_x + k*step, bounds check against ur_x,
// plus the x position of the following batch. Purely combinational.
module samp_step_gen
  import rast_pkg::*;
#(
  parameter int SIGFIG = SIGFIG_DEF,
  parameter int SAMPS  = SAMPS_DEF
) (
  input  logic signed [SIGFIG-1:0]        cur_x,
  input  logic        [SIGFIG-1:0]        step,
  input  logic signed [SIGFIG-1:0]        ur_x,
  output logic        [SAMPS-1:0][SIGFIG-1:0] lane_x,
  output logic        [SAMPS-1:0]         lane_vld,
  output logic signed [SIGFIG+1:0]        next_x
);
  localparam int W = SIGFIG + 2;

  logic signed [W-1:0] step_w;
  logic signed [W-1:0] ur_w;
  logic signed [W-1:0] off [SAMPS+1];

  // Two guard bits keep lanes past ur from wrapping back into range.
  assign step_w = {2'b00, step};
  assign ur_w   = {{2{ur_x[SIGFIG-1]}}, ur_x};
  assign off[0] = {{2{cur_x[SIGFIG-1]}}, cur_x};

  for (genvar k = 0; k < SAMPS; k++) begin : g_lane
    assign off[k+1]    = off[k] + step_w;
    assign lane_x[k]   = off[k][SIGFIG-1:0];
    assign lane_vld[k] = (off[k] <= ur_w);
  end

  assign next_x = off[SAMPS];
endmodule

// File: rtl/samp_sched.sv
// Sample scheduler: walks a triangle's bounding box in raster order, SAMPS samples per cycle.
// First batch the cycle after accept; halt_RnnH freezes everything; busy while issuing.
module samp_sched
  import rast_pkg::*;
#(
  parameter int SIGFIG = SIGFIG_DEF,
  parameter int RADIX  = RADIX_DEF,
  parameter int VERTS  = 3,
  parameter int AXIS   = 3,
  parameter int COLORS = 3,
  parameter int SAMPS  = SAMPS_DEF
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R13S,
  input  logic        [COLORS-1:0][SIGFIG-1:0]        color_R13U,
  input  logic signed [1:0][1:0][SIGFIG-1:0]          box_R13S,
  input  logic        [SIGFIG-1:0]                    step_R13U,
  input  logic                                        validTri_R13H,
  input  logic                                        halt_RnnH,
  output logic                                        halt_R13H,
  output logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R16S,
  output logic        [COLORS-1:0][SIGFIG-1:0]        color_R16U,
  output logic signed [1:0][SAMPS-1:0][SIGFIG-1:0]    sample_R16S,
  output logic        [SAMPS-1:0]                     validSamp_R16H
);
  localparam int W = SIGFIG + 2;

  state_t state_q, state_d;
  logic signed [SIGFIG-1:0] cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic signed [SIGFIG-1:0] ll_x_q, ll_x_d, ur_x_q, ur_x_d, ur_y_q, ur_y_d;
  logic        [SIGFIG-1:0] step_q, step_d;
  logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_q, tri_d;
  logic        [COLORS-1:0][SIGFIG-1:0] color_q, color_d;

  logic signed [W-1:0] next_x, next_y, ur_x_w, ur_y_w, cur_y_w, step_w;
  logic [SAMPS-1:0][SIGFIG-1:0] lane_x;
  logic [SAMPS-1:0] lane_vld;
  logic box_ok, accept;

  samp_step_gen #(
    .SIGFIG (SIGFIG),
    .SAMPS  (SAMPS)
  ) u_step_gen (
    .cur_x    (cur_x_q),
    .step     (step_q),
    .ur_x     (ur_x_q),
    .lane_x   (lane_x),
    .lane_vld (lane_vld),
    .next_x   (next_x)
  );

  assign halt_R13H = (state_q == ST_ISSUE);
  assign accept    = validTri_R13H && !halt_R13H;
  assign box_ok    = ($signed(box_R13S[0][0]) <= $signed(box_R13S[1][0])) &&
                     ($signed(box_R13S[0][1]) <= $signed(box_R13S[1][1]));

  assign ur_x_w  = {{2{ur_x_q[SIGFIG-1]}}, ur_x_q};
  assign ur_y_w  = {{2{ur_y_q[SIGFIG-1]}}, ur_y_q};
  assign cur_y_w = {{2{cur_y_q[SIGFIG-1]}}, cur_y_q};
  assign step_w  = {2'b00, step_q};
  assign next_y  = cur_y_w + step_w;

  always_comb begin
    state_d = state_q;
    cur_x_d = cur_x_q;
    cur_y_d = cur_y_q;
    ll_x_d  = ll_x_q;
    ur_x_d  = ur_x_q;
    ur_y_d  = ur_y_q;
    step_d  = step_q;
    tri_d   = tri_q;
    color_d = color_q;
    if (accept) begin
      tri_d   = tri_R13S;
      color_d = color_R13U;
      step_d  = step_R13U;
      ll_x_d  = box_R13S[0][0];
      ur_x_d  = box_R13S[1][0];
      ur_y_d  = box_R13S[1][1];
      cur_x_d = box_R13S[0][0];
      cur_y_d = box_R13S[0][1];
      // Inverted boxes are swallowed here: latched but never issued.
      if (box_ok) state_d = ST_ISSUE;
    end else if (state_q == ST_ISSUE && !halt_RnnH) begin
      if (next_x <= ur_x_w) begin
        cur_x_d = next_x[SIGFIG-1:0];
      end else begin
        cur_x_d = ll_x_q;
        cur_y_d = next_y[SIGFIG-1:0];
        if (next_y > ur_y_w) state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cur_x_q <= '0;
      cur_y_q <= '0;
      ll_x_q  <= '0;
      ur_x_q  <= '0;
      ur_y_q  <= '0;
      step_q  <= '0;
      tri_q   <= '0;
      color_q <= '0;
    end else begin
      state_q <= state_d;
      cur_x_q <= cur_x_d;
      cur_y_q <= cur_y_d;
      ll_x_q  <= ll_x_d;
      ur_x_q  <= ur_x_d;
      ur_y_q  <= ur_y_d;
      step_q  <= step_d;
      tri_q   <= tri_d;
      color_q <= color_d;
    end
  end

  always_comb begin
    sample_R16S[0] = lane_x;
    for (int k = 0; k < SAMPS; k++) sample_R16S[1][k] = cur_y_q;
    validSamp_R16H = (state_q == ST_ISSUE) ? lane_vld : '0;
  end

  assign tri_R16S   = tri_q;
  assign color_R16U = color_q;
endmodule

// File: tb/tb_samp_sched.sv
// Scoreboard bench for samp_sched: a raster model queues expected batches, a negedge monitor retires them.
module tb_samp_sched;
  localparam int STEP = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic signed [2:0][2:0][23:0] tri_in = '0;
  logic [2:0][23:0] color_in = '0;
  logic signed [1:0][1:0][23:0] box_in = '0;
  logic [23:0] step_in = 24'(STEP);
  logic valid_tri = 1'b0;
  logic halt_dn = 1'b0;
  logic halt_up;
  logic signed [2:0][2:0][23:0] tri_out;
  logic [2:0][23:0] color_out;
  logic signed [1:0][3:0][23:0] samp_out;
  logic [3:0] vld_out;

  typedef struct {
    int x0;
    int y;
    logic [3:0] vld;
  } batch_t;

  batch_t exp_q[$];
  int checks = 0;
  int errors = 0;

  samp_sched dut (
    .clk            (clk),
    .rst            (rst),
    .tri_R13S       (tri_in),
    .color_R13U     (color_in),
    .box_R13S       (box_in),
    .step_R13U      (step_in),
    .validTri_R13H  (valid_tri),
    .halt_RnnH      (halt_dn),
    .halt_R13H      (halt_up),
    .tri_R16S       (tri_out),
    .color_R16U     (color_out),
    .sample_R16S    (samp_out),
    .validSamp_R16H (vld_out)
  );

  always #5 clk = ~clk;

  // Reference raster walk over the box with 4 lanes.
  task automatic push_box(input int llx, input int lly, input int urx, input int ury);
    batch_t b;
    if (llx > urx || lly > ury) return;
    for (int y = lly; y <= ury; y += STEP)
      for (int x = llx; x <= urx; x += 4 * STEP) begin
        b.x0 = x;
        b.y  = y;
        for (int k = 0; k < 4; k++) b.vld[k] = (x + k * STEP <= urx);
        exp_q.push_back(b);
      end
  endtask

  task automatic set_box(input int llx, input int lly, input int urx, input int ury);
    box_in[0][0] = 24'(llx);
    box_in[0][1] = 24'(lly);
    box_in[1][0] = 24'(urx);
    box_in[1][1] = 24'(ury);
  endtask

  always @(negedge clk) begin
    batch_t eb;
    logic [1:0][3:0][23:0] es;
    if (!rst && vld_out != 4'b0 && !halt_dn) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_batch got x0=%0d y=%0d vld=%b, required no batch",
                 $signed(samp_out[0][0]), $signed(samp_out[1][0]), vld_out);
      end else begin
        eb = exp_q.pop_front();
        for (int k = 0; k < 4; k++) begin
          es[0][k] = 24'(eb.x0 + k * STEP);
          es[1][k] = 24'(eb.y);
        end
        if ({vld_out, samp_out} !== {eb.vld, es}) begin
          errors++;
          $display("FAIL batch got x0=%0d y=%0d vld=%b x3=%0d, required x0=%0d y=%0d vld=%b x3=%0d",
                   $signed(samp_out[0][0]), $signed(samp_out[1][0]), vld_out, $signed(samp_out[0][3]),
                   eb.x0, eb.y, eb.vld, eb.x0 + 3 * STEP);
        end
      end
    end
  end

  task automatic test_reset;
    for (int v = 0; v < 3; v++) begin
      color_in[v] = 24'($urandom);
      for (int a = 0; a < 3; a++) tri_in[v][a] = 24'($urandom);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (vld_out !== 4'b0) begin errors++; $display("FAIL reset_vld got %b required 0000", vld_out); end
    checks++;
    if (halt_up !== 1'b0) begin errors++; $display("FAIL reset_halt got %b required 0", halt_up); end
    checks++;
    if (samp_out !== '0) begin errors++; $display("FAIL reset_sample got %h required 0", samp_out); end
    checks++;
    if (tri_out !== '0 || color_out !== '0) begin
      errors++;
      $display("FAIL reset_tri_color got %h/%h required 0", tri_out, color_out);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_basic;
    logic signed [2:0][2:0][23:0] tri_exp;
    logic [2:0][23:0] color_exp;
    int hcnt = 0;
    @(posedge clk); #1;
    set_box(0, 0, 5120, 1024);
    tri_exp   = tri_in;
    color_exp = color_in;
    valid_tri = 1'b1;
    push_box(0, 0, 5120, 1024);
    @(posedge clk); #1;
    valid_tri = 1'b0;
    tri_in    = ~tri_in;
    color_in  = ~color_in;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (halt_up) hcnt++;
    end
    checks++;
    if (hcnt != 4) begin errors++; $display("FAIL basic_busy_cycles got %0d required 4", hcnt); end
    checks++;
    if (tri_out !== tri_exp || color_out !== color_exp) begin
      errors++;
      $display("FAIL basic_latch got %h/%h required %h/%h", tri_out, color_out, tri_exp, color_exp);
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL basic_drain got %0d left required 0", exp_q.size()); end
  endtask

  task automatic test_halt;
    int hold = 0;
    int bad  = 0;
    @(posedge clk); #1;
    set_box(0, 0, 5120, 1024);
    valid_tri = 1'b1;
    push_box(0, 0, 5120, 1024);
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      valid_tri = 1'b0;
      halt_dn   = (i >= 1 && i <= 3);
      @(negedge clk);
      if (vld_out == 4'b0011 && $signed(samp_out[0][0]) == 4096 && $signed(samp_out[1][0]) == 0) hold++;
      if (halt_dn && !halt_up) bad++;
    end
    checks++;
    if (hold != 4) begin errors++; $display("FAIL halt_hold_cycles got %0d required 4", hold); end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL halt_busy got %0d idle cycles required 0", bad); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL halt_drain got %0d left required 0", exp_q.size()); end
  endtask

  task automatic test_degenerate;
    int bad = 0;
    @(posedge clk); #1;
    set_box(1024, 0, 0, 0);
    valid_tri = 1'b1;
    push_box(1024, 0, 0, 0);
    @(posedge clk); #1;
    valid_tri = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (vld_out != 4'b0 || halt_up) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL degenerate got %0d active cycles required 0", bad); end
  endtask

  task automatic test_reset_mid;
    @(posedge clk); #1;
    set_box(0, 0, 5120, 2048);
    valid_tri = 1'b1;
    push_box(0, 0, 5120, 2048);
    @(posedge clk); #1;
    valid_tri = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    checks++;
    if (vld_out !== 4'b0 || halt_up !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_async got vld=%b halt=%b required 0000/0", vld_out, halt_up);
    end
    checks++;
    if (samp_out !== '0) begin errors++; $display("FAIL reset_mid_sample got %h required 0", samp_out); end
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (exp_q.size() != 2) begin errors++; $display("FAIL reset_mid_leftover got %0d required 2", exp_q.size()); end
    exp_q.delete();
    set_box(2048, 1024, 3072, 1024);
    valid_tri = 1'b1;
    push_box(2048, 1024, 3072, 1024);
    @(posedge clk); #1;
    valid_tri = 1'b0;
    checks++;
    if (halt_up !== 1'b1) begin errors++; $display("FAIL reset_first_accept got halt=%b required 1", halt_up); end
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL reset_mid_drain got %0d left required 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back;
    int nb = 0;
    int first = -1;
    int last = -1;
    @(posedge clk); #1;
    set_box(0, 0, 1024, 0);
    valid_tri = 1'b1;
    for (int t = 0; t < 3; t++) push_box(0, 0, 1024, 0);
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (i == 4) valid_tri = 1'b0;
      @(negedge clk);
      if (vld_out != 4'b0) begin
        nb++;
        if (first < 0) first = i;
        last = i;
      end
    end
    checks++;
    if (nb != 3 || last - first != 4) begin
      errors++;
      $display("FAIL back_to_back got %0d batches span %0d required 3 span 4", nb, last - first);
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_drain got %0d left required 0", exp_q.size()); end
  endtask

  task automatic test_signed;
    int hcnt = 0;
    @(posedge clk); #1;
    set_box(-2048, -1024, -1024, -1024);
    valid_tri = 1'b1;
    push_box(-2048, -1024, -1024, -1024);
    @(posedge clk); #1;
    valid_tri = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (halt_up) hcnt++;
    end
    checks++;
    if (hcnt != 1) begin errors++; $display("FAIL signed_busy_cycles got %0d required 1", hcnt); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL signed_drain got %0d left required 0", exp_q.size()); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_halt;
    test_degenerate;
    test_reset_mid;
    test_back_to_back;
    test_signed;
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/samp_sched.md
SAMP_SCHED -- requirements
Module: samp_sched

Interface
REQ-001 SHALL have parameter SIGFIG, default 24, meaning bits per fixed-point coordinate or colour.
REQ-002 SHALL have parameter RADIX, default 10, meaning fraction bits.
REQ-003 SHALL have parameters VERTS=3, AXIS=3 and COLORS=3, meaning triangle vertices, axes per vertex and colour channels.
REQ-004 SHALL have parameter SAMPS, default 4, meaning samples issued per cycle (power of two).
REQ-005 SHALL have port clk, input, width 1, the single clock; one clock domain only.
REQ-006 SHALL have port rst, input, width 1, an asynchronous active-high reset.
REQ-007 SHALL have tri_R13S, input, signed SIGFIG[VERTS][AXIS], the triangle; and color_R13U, input, SIGFIG[COLORS], its colour.
REQ-008 SHALL have box_R13S, input, signed SIGFIG[2][2], where [0] is lower-left (x,y) and [1] is upper-right (x,y), both snapped to the sample grid.
REQ-009 SHALL have step_R13U, input, SIGFIG, the sample pitch (greater than 0), sampled only at accept.
REQ-010 SHALL have validTri_R13H, input, width 1, which qualifies the triangle, box and step inputs.
REQ-011 SHALL have halt_RnnH, input, width 1, a downstream stall.
REQ-012 SHALL have halt_R13H, output, width 1, an upstream stall; a triangle is accepted when validTri_R13H is high and halt_R13H is low.
REQ-013 SHALL have tri_R16S and color_R16U, outputs, holding the latched triangle and colour.
REQ-014 SHALL have sample_R16S, output, signed SIGFIG[2][SAMPS], the sample locations.
REQ-015 SHALL have validSamp_R16H, output, 1[SAMPS], per-sample valid flags.

Function
REQ-016 SHALL implement a two-state FSM, IDLE and ISSUE.
REQ-017 SHALL drive halt_R13H = (state==ISSUE).
REQ-018 On accept in IDLE with a non-degenerate box, SHALL:
- latch tri, color, box and step;
- set cur_x = ll_x and cur_y = ll_y;
- enter ISSUE the next cycle.
REQ-019 A box with ll_x>ur_x or ll_y>ur_y SHALL be accepted and dropped: stay in IDLE, issue no batch.
REQ-020 In ISSUE, outputs SHALL be as follows:
- sample_R16S[0][k] = cur_x + k*step;
- sample_R16S[1][k] = cur_y;
- validSamp_R16H[k] = (cur_x + k*step <= ur_x).
REQ-021 In IDLE, all validSamp_R16H bits SHALL be 0; other outputs may hold stale values.
REQ-022 While halt_RnnH=1, cur_x, cur_y, the state and all outputs SHALL hold unchanged.
REQ-023 In ISSUE with halt_RnnH=0, SHALL advance: nx = cur_x + SAMPS*step.
- If nx <= ur_x, then cur_x = nx.
- Otherwise cur_x = ll_x and cur_y = cur_y + step.
- If the new cur_y > ur_y, return to IDLE.
REQ-024 A batch is consumed on each ISSUE cycle with halt_RnnH=0. The first batch appears in the cycle after accept. A new triangle may be accepted in the cycle after the last batch is consumed.
REQ-025 Coordinate arithmetic SHALL use SIGFIG+2-bit signed intermediates so that advancing past ur does not wrap. Comparisons SHALL be signed.
REQ-026 Batches with validSamp all 0 SHALL never be issued, because every row starts at ll_x <= ur_x.
REQ-027 Scan order SHALL be raster: x ascending within a row, rows ascending in y.

Reset
REQ-028 Asserting rst SHALL, at any time including mid-ISSUE:
- force state to IDLE;
- clear validSamp_R16H, sample_R16S, tri_R16S, color_R16U and the cur and box registers to 0;
- drive halt_R13H low.
REQ-029 After rst deasserts, SHALL accept on the first clock edge with validTri_R13H high.

Structure
REQ-030 The state enum and the default SIGFIG/RADIX/SAMPS constants SHALL live in the shared package rast_pkg.
REQ-031 Per-lane address generation (cur + k*step, compare against ur) SHALL be a sub-module samp_step_gen instanced once with SAMPS lanes. The FSM and registers SHALL remain in samp_sched.

Verification
All scenarios use step = 1.0 = 1024 and SAMPS=4.
REQ-032 Box (0,0)-(5120,1024), no halt, SHALL issue 4 batches:
- x0 = 0,4096 on y=0, then on y=1024;
- validSamp = 1111, 0011, 1111, 0011;
- then IDLE, with halt_R13H high for exactly 4 cycles.
REQ-033 The same box with halt_RnnH=1 during batch 2 for 3 cycles SHALL hold batch 2 (0011, x0=4096) for 4 cycles, with no skipped or duplicated batch.
REQ-034 Degenerate box (1024,0)-(0,0) SHALL produce no validSamp, and halt_R13H SHALL stay low.
REQ-035 Asserting rst asynchronously mid-row-2 SHALL clear validSamp immediately; a new box accepted afterwards SHALL start at its own ll corner.
REQ-036 Back-to-back triangles, validTri_R13H held high, SHALL be accepted in the cycle after the last batch is consumed, with no idle batch gap beyond one cycle.
REQ-037 Box (-2048,-1024)-(-1024,-1024) SHALL issue one batch with x0=-2048 and validSamp=0011, confirming signed compares.
